crypto_wallet_sw_ctrl: RTL and testbench
========================================

Name: crypto_wallet_sw_ctrl

Overview:
- Avalon-MM slave controller for the wallet's 4-bit slide-switch input.
- Adds input synchronisation, per-bit debounce, edge capture with write-1-to-clear, and a maskable interrupt.
- Sits between the board switch pins and the Qsys interconnect, and lets the Nios firmware react to switch changes by interrupt instead of polling.

Parameters:
- WIDTH, 4: number of switch inputs (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a synchronised input must hold a new level before it is accepted (>=2).
- EDGE_TYPE, 0: edge-capture mode. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register word offset.
- chipselect  input  1  slave select; qualifies writes only.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw switch pins, asynchronous to clk.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, registered.

Behaviour:
- Interface decided: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: readdata=0, irq=0, mask=0, edge_capture=0, debounced=0, sync flops=0, counters=0, all per-bit FSMs in STABLE.
- Synchroniser: 2-flop chain per bit (sync1 -> sync2). Pin-to-sync2 latency is 2 cycles.
- Per-bit debounce FSM, with an independent counter of width clog2(DEBOUNCE_CYCLES):
  - STABLE: if sync2 != debounced, go to COUNTING with cnt=1. Otherwise cnt=0.
  - COUNTING: if sync2 == debounced (glitch), return to STABLE with cnt=0. Else if cnt == DEBOUNCE_CYCLES-1, set debounced <= sync2, cnt=0, go to STABLE. Else cnt++.
  - A new level is accepted exactly DEBOUNCE_CYCLES cycles after it first appears on sync2. Any bounce restarts the count.
- Edge detect: a 1-cycle pulse per bit when debounced changes, filtered by EDGE_TYPE.
- Register map (32-bit words, unused bits read 0):
  - 0 DATA (RO): debounced[WIDTH-1:0]. Writes ignored.
  - 1 IRQMASK (RW): mask[WIDTH-1:0].
  - 2 RESERVED: reads 0, writes ignored.
  - 3 EDGECAP (R/W1C): edge_capture[WIDTH-1:0].
- Write = chipselect & ~write_n, taking effect on the next clk edge.
- Reads have no chipselect qualification. readdata is registered every cycle from the current address, giving read latency 1 (Qsys readLatency=1, no waitrequest).
- EDGECAP: bit i is set on an edge pulse and cleared by a write with writedata[i]=1 to offset 3. If set and clear happen in the same cycle, the set wins and the bit stays 1.
- irq <= |(edge_capture & mask), registered, so irq follows edge_capture by 1 cycle. Once asserted it stays high until the capture bit is cleared or the mask bit is cleared.
- A mask write does not alter edge_capture.
- Reset mid-count: counters drop to 0, debounced drops to 0 and pending captures are lost. After release, a switch held high is re-accepted after 2+DEBOUNCE_CYCLES cycles and produces a rising edge.
- Writes to any offset with chipselect=0 are ignored.

Decomposition:
- Shared package crypto_wallet_sw_pkg holds:
  - register offsets: SW_DATA_OFS=0, SW_MASK_OFS=1, SW_EDGE_OFS=3;
  - EDGE_TYPE constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2;
  - the debounce FSM state enum: ST_STABLE, ST_COUNTING.
- Sub-module crypto_wallet_sw_debounce is a single-bit synchroniser plus debounce FSM plus edge pulse, with parameters DEBOUNCE_CYCLES and EDGE_TYPE. It is generated WIDTH times in the top level.
- The top level holds the register file, the read mux and irq.

Test Plan (bench uses DEBOUNCE_CYCLES=4, EDGE_TYPE=0):
- Reset with in_port=4'b1010 held, release at cycle 0 -> DATA read returns 0x0 until cycle 6, returns 0xA from cycle 7. EDGECAP=0xA. irq stays 0 (mask=0).
- Clean rise: write IRQMASK=0x1, drive in_port[0] 0->1 -> irq rises exactly 2+4+2 cycles after the pin change. EDGECAP=0x1. Write 0x1 to offset 3 -> EDGECAP=0, irq falls 2 cycles after the write.
- Bounce: toggle in_port[1] high for 3 cycles, low for 1, then high steady -> DATA[1] updates only 4 cycles after the last rise reaches sync2. Exactly one EDGECAP[1] set.
- Set/clear collision: time a W1C write of 0x4 to offset 3 on the same cycle the bit-2 edge pulse fires -> EDGECAP[2] reads 1 afterwards.
- Falling edge only: with EDGE_TYPE=0, drive in_port[3] 1->0 -> DATA[3]=0 and EDGECAP unchanged. Rerun with EDGE_TYPE=1 -> EDGECAP=0x8.
- Bus hygiene: write 0xFFFFFFFF to offsets 0 and 2, and to offset 1 with chipselect=0 -> DATA unchanged, offset 2 reads 0, IRQMASK unchanged. Read offset 1 after a legal write of 0xFFFFFFFF -> readdata=0x0000000F one cycle after the address is presented.

Source files
------------

// File: rtl/crypto_wallet_sw_pkg.sv
// rtl/crypto_wallet_sw_pkg.sv - shared offsets, edge modes and debounce state type for the switch controller
package crypto_wallet_sw_pkg;

  // Register word offsets on the Avalon-MM slave
  localparam logic [1:0] SW_DATA_OFS = 2'd0;
  localparam logic [1:0] SW_MASK_OFS = 2'd1;
  localparam logic [1:0] SW_EDGE_OFS = 2'd3;

  // Edge-capture modes
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } sw_deb_state_t;

  // True when a transition to new_level is of interest for the given mode
  function automatic logic sw_edge_wanted(input int edge_type, input logic new_level);
    case (edge_type)
      EDGE_RISE: sw_edge_wanted = new_level;
      EDGE_FALL: sw_edge_wanted = ~new_level;
      default:   sw_edge_wanted = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/crypto_wallet_sw_debounce.sv
// rtl/crypto_wallet_sw_debounce.sv - one switch bit: 2-flop synchroniser, debounce FSM and edge pulse
module crypto_wallet_sw_debounce
  import crypto_wallet_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  sw_deb_state_t state;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES samples; pulse on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (sync2 != level) begin
            state <= ST_COUNTING;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNTING: begin
          if (sync2 == level) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            level      <= sync2;
            edge_pulse <= sw_edge_wanted(EDGE_TYPE, sync2);
            cnt        <= '0;
            state      <= ST_STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/crypto_wallet_sw_ctrl.sv
// rtl/crypto_wallet_sw_ctrl.sv - Avalon-MM switch controller: debounced data, irq mask, W1C edge capture
module crypto_wallet_sw_ctrl
  import crypto_wallet_sw_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_clear;
  logic [31:0]      read_mux;
  logic             wr_en;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    crypto_wallet_sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_TYPE       (EDGE_TYPE)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .pin        (in_port[gi]),
      .level      (debounced[gi]),
      .edge_pulse (edge_pulse[gi])
    );
  end

  assign wr_en      = chipselect & ~write_n;
  assign edge_clear = (wr_en && address == SW_EDGE_OFS) ? writedata[WIDTH-1:0] : '0;

  // Interrupt mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (wr_en && address == SW_MASK_OFS) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  // Edge capture: write-1-to-clear, a same-cycle edge keeps the bit set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | edge_pulse;
    end
  end

  // Select the word addressed this cycle; unused bits and the reserved offset read 0
  always_comb begin
    read_mux = '0;
    case (address)
      SW_DATA_OFS: read_mux[WIDTH-1:0] = debounced;
      SW_MASK_OFS: read_mux[WIDTH-1:0] = mask;
      SW_EDGE_OFS: read_mux[WIDTH-1:0] = edge_capture;
      default:     read_mux = '0;
    endcase
  end

  // Registered read data (latency 1) and level interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= read_mux;
      irq      <= |(edge_capture & mask);
    end
  end

endmodule

// File: tb/tb_crypto_wallet_sw_ctrl.sv
// tb/tb_crypto_wallet_sw_ctrl.sv - randomized and directed bench for crypto_wallet_sw_ctrl against a reference model
module tb_crypto_wallet_sw_ctrl;

  localparam int W  = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd_r, rd_f;
  logic          irq_r, irq_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  crypto_wallet_sw_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_r), .irq(irq_r)
  );

  crypto_wallet_sw_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1)) u_dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_f), .irq(irq_f)
  );

  // Reference model: index 0 = rising-edge instance, 1 = falling-edge instance
  logic [W-1:0]  m_s1, m_s2, m_deb, m_deb_prev, m_mask;
  logic [DB-1:0] m_hist [W];
  logic [W-1:0]  m_ecap [2];
  logic          m_irq [2];
  logic [31:0]   m_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0; m_mask = '0;
    for (int b = 0; b < W; b++) m_hist[b] = '0;
    for (int e = 0; e < 2; e++) begin
      m_ecap[e] = '0; m_irq[e] = 1'b0; m_rd[e] = '0;
    end
  endtask

  // One clock edge of the model, using the inputs that were present at that edge
  task automatic model_step();
    logic [W-1:0] chg, clr, n_deb;
    logic         wr;
    wr  = chipselect & ~write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    chg = m_deb ^ m_deb_prev;
    for (int e = 0; e < 2; e++) begin
      case (address)
        2'd0:    m_rd[e] = {28'd0, m_deb};
        2'd1:    m_rd[e] = {28'd0, m_mask};
        2'd3:    m_rd[e] = {28'd0, m_ecap[e]};
        default: m_rd[e] = 32'd0;
      endcase
      m_irq[e]  = |(m_ecap[e] & m_mask);
      m_ecap[e] = (m_ecap[e] & ~clr) | (chg & ((e == 0) ? m_deb : ~m_deb));
    end
    if (wr && address == 2'd1) m_mask = writedata[W-1:0];
    n_deb = m_deb;
    for (int b = 0; b < W; b++) begin
      m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
      if (m_hist[b] == {DB{~m_deb[b]}}) n_deb[b] = ~m_deb[b];
    end
    m_deb_prev = m_deb;
    m_deb      = n_deb;
    m_s2       = m_s1;
    m_s1       = in_port;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rd_rise",  rd_r, m_rd[0]);
    check("irq_rise", 32'(irq_r), 32'(m_irq[0]));
    check("rd_fall",  rd_f, m_rd[1]);
    check("irq_fall", 32'(irq_f), 32'(m_irq[1]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rd",  rd_r | rd_f, 32'd0);
    check("reset_irq", 32'(irq_r | irq_f), 32'd0);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
    address = a; chipselect = cs; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  initial begin
    int  lat;
    bit  found;
    model_reset();
    @(negedge clk);

    // Reset with switches held at 1010
    in_port = 4'b1010;
    address = 2'd0;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 6) check("rst_data_c6", rd_r, 32'h0);
      if (c == 7) check("rst_data_c7", rd_r, 32'hA);
    end
    address = 2'd3;
    tick();
    check("rst_ecap", rd_r, 32'hA);
    check("rst_irq",  32'(irq_r), 32'd0);

    // Clean rise on bit 0 with mask 0x1
    bus_write(2'd3, 32'hF, 1'b1);
    bus_write(2'd1, 32'h1, 1'b1);
    in_port[0] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (irq_r && lat == 0) lat = c;
    end
    check("rise_irq_latency", 32'(lat), 32'd8);
    address = 2'd3;
    tick();
    check("rise_ecap", rd_r, 32'h1);
    bus_write(2'd3, 32'h1, 1'b1);
    check("clr_irq_hold", 32'(irq_r), 32'd1);
    tick();
    check("clr_irq_fall", 32'(irq_r), 32'd0);
    check("clr_ecap", rd_r, 32'h0);

    // Bounce on bit 1
    in_port[1] = 1'b0;
    repeat (10) tick();
    bus_write(2'd3, 32'hF, 1'b1);
    address = 2'd0;
    in_port[1] = 1'b1;
    repeat (3) tick();
    in_port[1] = 1'b0;
    tick();
    in_port[1] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rd_r[1] && lat == 0) lat = c;
    end
    check("bounce_data_latency", 32'(lat), 32'd7);
    address = 2'd3;
    tick();
    check("bounce_ecap", rd_r, 32'h2);

    // Set/clear collision on bit 2
    bus_write(2'd3, 32'hF, 1'b1);
    in_port[2] = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_deb[2] != m_deb_prev[2]) found = 1'b1;
    end
    check("collide_found", 32'(found), 32'd1);
    bus_write(2'd3, 32'h4, 1'b1);
    tick();
    check("collide_ecap2", 32'(rd_r[2]), 32'd1);

    // Falling edge on bit 3
    bus_write(2'd3, 32'hF, 1'b1);
    in_port[3] = 1'b0;
    repeat (10) tick();
    address = 2'd0;
    tick();
    check("fall_data3", 32'(rd_r[3]), 32'd0);
    address = 2'd3;
    tick();
    check("fall_ecap_rise_inst", rd_r, 32'h0);
    check("fall_ecap_fall_inst", rd_f, 32'h8);

    // Bus hygiene
    bus_write(2'd0, 32'hFFFF_FFFF, 1'b1);
    bus_write(2'd2, 32'hFFFF_FFFF, 1'b1);
    bus_write(2'd1, 32'hFFFF_FFFF, 1'b0);
    address = 2'd0;
    tick();
    check("hyg_data", rd_r, 32'h7);
    address = 2'd2;
    tick();
    check("hyg_reserved", rd_r, 32'h0);
    address = 2'd1;
    tick();
    check("hyg_mask_kept", rd_r, 32'h1);
    bus_write(2'd1, 32'hFFFF_FFFF, 1'b1);
    address = 2'd1;
    tick();
    check("hyg_mask_written", rd_r, 32'hF);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        int idx;
        idx = $urandom_range(0, W - 1);
        in_port[idx] = ~in_port[idx];
      end
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        chipselect = 1'b0; write_n = 1'b1;
        do_reset();
      end else begin
        tick();
      end
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
